// File: rtl/fpu_pkg.sv
// Shared constants, types and helpers for the arithmetic sharing blocks.
// Operand buses are packed per requester, lowest index in the low bits.
package fpu_pkg;

    localparam int ADD_W       = 40;
    localparam int NUM_REQ_DEF = 2;
    localparam int ID_W_DEF    = $clog2(NUM_REQ_DEF);
    localparam int MAX_REQ     = 4;

    typedef logic [ID_W_DEF-1:0] req_id_t;

    // Pick one ADD_W-wide operand out of a bus padded to MAX_REQ slots.
    function automatic logic [ADD_W-1:0] op_slice(
        input logic [MAX_REQ*ADD_W-1:0] bus,
        input logic [1:0]               idx
    );
        return bus[idx*ADD_W +: ADD_W];
    endfunction

endpackage

// File: rtl/adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups.
// WIDTH must be a multiple of 4; the final carry-out is dropped.
module adder #(
    parameter int WIDTH = 40
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin : p_cla
        logic       carry;
        logic [4:0] c;
        logic [3:0] gg;
        logic [3:0] pp;
        carry = i_cin;
        c     = '0;
        gg    = '0;
        pp    = '0;
        o_sum = '0;
        for (int k = 0; k < WIDTH / 4; k++) begin
            gg   = w_g[4*k +: 4];
            pp   = w_p[4*k +: 4];
            c[0] = carry;
            c[1] = gg[0] | (pp[0] & c[0]);
            c[2] = gg[1] | (pp[1] & gg[0])
                 | (pp[1] & pp[0] & c[0]);
            c[3] = gg[2] | (pp[2] & gg[1])
                 | (pp[2] & pp[1] & gg[0])
                 | ((&pp[2:0]) & c[0]);
            c[4] = gg[3] | (pp[3] & gg[2])
                 | (pp[3] & pp[2] & gg[1])
                 | ((&pp[3:1]) & gg[0])
                 | ((&pp) & c[0]);
            o_sum[4*k +: 4] = pp ^ c[3:0];
            carry = c[4];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
// Grant is one-hot or zero; the encoded index is 0 when nothing is granted.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx
);

    always_comb begin : p_search
        logic            found;
        int              pos;
        logic [ID_W-1:0] sel;
        found       = 1'b0;
        pos         = 0;
        sel         = '0;
        o_grant     = '0;
        o_grant_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = (int'(i_last_grant) + k) % NUM_REQ;
            sel = ID_W'(pos);
            if (!found && i_req[sel]) begin
                found        = 1'b1;
                o_grant[sel] = 1'b1;
                o_grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one carry-lookahead adder between NUM_REQ requesters through a
// two-stage pipeline (operand register -> adder -> result register).
module adder_arbiter
    import fpu_pkg::*;
#(
    parameter int WIDTH   = ADD_W,
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy
);

    logic [NUM_REQ-1:0]       w_grant;
    logic [ID_W-1:0]          w_grant_idx;
    logic                     w_s2_adv;
    logic                     w_s1_rdy;
    logic                     w_accept;
    logic [MAX_REQ*ADD_W-1:0] w_a_ext;
    logic [MAX_REQ*ADD_W-1:0] w_b_ext;
    logic [WIDTH-1:0]         w_op_a;
    logic [WIDTH-1:0]         w_op_b;
    logic [WIDTH-1:0]         w_sum;

    logic [ID_W-1:0]  r_last_grant;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_sum;
    logic [ID_W-1:0]  r_rsp_id;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req        (req_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    // Stage 1 may load whenever it is empty or stage 2 is moving.
    assign w_s2_adv  = ~r_rsp_valid | rsp_ready;
    assign w_s1_rdy  = ~r_s1_valid | w_s2_adv;
    assign req_ready = w_grant & {NUM_REQ{w_s1_rdy & ~rst}};
    assign w_accept  = |(req_valid & req_ready);

    assign w_a_ext = (MAX_REQ*ADD_W)'(req_a);
    assign w_b_ext = (MAX_REQ*ADD_W)'(req_b);
    assign w_op_a  = op_slice(w_a_ext, 2'(w_grant_idx));
    assign w_op_b  = op_slice(w_b_ext, 2'(w_grant_idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (w_accept) begin
            r_last_grant <= w_grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
        end else if (w_s1_rdy) begin
            r_s1_valid <= w_accept;
            r_s1_a     <= w_op_a;
            r_s1_b     <= w_op_b;
            r_s1_id    <= w_grant_idx;
        end
    end

    adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a   (r_s1_a),
        .i_b   (r_s1_b),
        .i_cin (1'b0),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
        end else if (w_s2_adv) begin
            r_rsp_valid <= r_s1_valid;
            r_rsp_sum   <= w_sum;
            r_rsp_id    <= r_s1_id;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign busy      = r_s1_valid | r_rsp_valid;

endmodule
